// File: rtl/clyde_sb_pkg.sv
// Shared types and defaults for the Clyde S-box layer sequencer.
package clyde_sb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sb_state_e;

  localparam int LAT_DEF    = 3;
  localparam int NCHUNK_DEF = 4;

  // Chunk index width; a single chunk still needs one bit to carry an index.
  function automatic int sb_idx_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/clyde_sb_seq_vld.sv
// Valid-token shift register tracking which S-box pipeline stages hold a real chunk.
module clyde_sb_seq_vld #(
  parameter int LAT = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_i,
  output logic [LAT-1:0] vld_o
);

  logic [LAT-1:0] vld_d;

  // Stage 0 takes the issue strobe, every later stage copies its predecessor.
  always_comb begin
    vld_d = vld_o << 1;
    vld_d[0] = in_i;
  end

  generate
    for (genvar k = 0; k < LAT; k++) begin : g_stage
      dff #(
        .W     (1),
        .ASYN  (1'b1),
        .RST_V (1'b0)
      ) u_dff (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (1'b1),
        .d_i   (vld_d[k]),
        .q_o   (vld_o[k])
      );
    end
  endgenerate

endmodule

// File: rtl/dff.sv
// Codebase flop with clock-enable and selectable asynchronous or synchronous reset.
module dff #(
  parameter int            W     = 1,
  parameter bit            ASYN  = 1'b1,
  parameter logic [W-1:0]  RST_V = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (ASYN) begin : g_async
      // Register with asynchronous reset to RST_V.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          q_o <= RST_V;
        end else if (en_i) begin
          q_o <= d_i;
        end
      end
    end else begin : g_sync
      // Register with reset sampled on the clock edge.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          q_o <= RST_V;
        end else if (en_i) begin
          q_o <= d_i;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/clyde_sb_seq.sv
// Sequencer for the pipelined masked S-box layer of Clyde: issues chunks into
// the LAT-stage share pipeline, enables only stages holding a real chunk and
// writes chunks back in order. Define CLYDE_SB_RND_HS_EN to gate each issue
// on the fresh-randomness handshake; otherwise the PRNG is assumed always valid.
module clyde_sb_seq
  import clyde_sb_pkg::*;
#(
  parameter  int LAT    = LAT_DEF,
  parameter  int NCHUNK = NCHUNK_DEF,
  localparam int IW     = sb_idx_w(NCHUNK)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  input  logic           rnd_valid,
  output logic           rnd_ready,
  output logic [IW-1:0]  in_sel,
  output logic [LAT-1:0] stage_en,
  output logic           out_we,
  output logic [IW-1:0]  out_sel
);

  // Issue counter must reach NCHUNK itself to close rnd_ready.
  localparam int CW = $clog2(NCHUNK + 1);

  sb_state_e      state_q, state_d;
  logic [CW-1:0]  iss_cnt_q, iss_cnt_d;
  logic [IW-1:0]  out_cnt_q, out_cnt_d;
  logic           done_q, done_d;
  logic           issue;
  logic [LAT-1:0] vld;

  clyde_sb_seq_vld #(
    .LAT (LAT)
  ) u_vld (
    .clk_i (clk),
    .rst_i (rst),
    .in_i  (issue),
    .vld_o (vld)
  );

  // Handshake and datapath control decoded from the current state and valid tokens.
  always_comb begin
    busy      = (state_q == RUN);
    rnd_ready = (state_q == RUN) && (iss_cnt_q < CW'(NCHUNK));
`ifdef CLYDE_SB_RND_HS_EN
    issue     = rnd_ready & rnd_valid;
`else
    // rnd_valid is read but can never hold back an issue here.
    issue     = rnd_ready & (rnd_valid | 1'b1);
`endif
    in_sel    = IW'(iss_cnt_q);
    out_we    = vld[LAT-1];
    out_sel   = out_cnt_q;
    done      = done_q;
    stage_en  = vld << 1;
    stage_en[0] = issue;
  end

  // Next-state logic: counters advance on issue and write-back, last write-back ends the layer.
  always_comb begin
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        iss_cnt_d = '0;
        out_cnt_d = '0;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          iss_cnt_d = iss_cnt_q + CW'(1);
        end
        if (out_we) begin
          if (out_cnt_q == IW'(NCHUNK - 1)) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            iss_cnt_d = '0;
            out_cnt_d = '0;
          end else begin
            out_cnt_d = out_cnt_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset discards any layer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      iss_cnt_q <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
    end
  end

endmodule
